uart_rx_core_p: RTL and testbench

- Parametrised UART receive engine, the next generation of the 16550-style receiver.
- Samples the serial line on an oversampling tick, assembles 5–8 bit characters with optional parity, and flags parity, framing and break errors.
- Emits a one-clock push strobe toward the RX FIFO and runs the character-timeout counter.
- Differs from the previous receiver in four ways: oversampling ratio is a parameter, timeout reload is computed rather than tabulated, a ready-made timeout flag is output, and error status is a separate bus from the data.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_core_p_if.sv | 26 ++
 rtl/uart_rx_timeout.sv | 51 +++++
 rtl/uart_rx_core_p.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_core_p.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared encodings for the uart_rx_core_p receive engine: FSM states, error-bus bit
// positions, line-control bit positions and the glitch-filter vote.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StParity   = 3'd3,
        StStop     = 3'd4,
        StPush     = 3'd5,
        StWaitIdle = 3'd6
    } rx_state_e;

    localparam int unsigned ErrBrk = 2;
    localparam int unsigned ErrPe  = 1;
    localparam int unsigned ErrFe  = 0;

    localparam int unsigned LcrWls = 0;  // [1:0] word length select
    localparam int unsigned LcrStb = 2;
    localparam int unsigned LcrPen = 3;
    localparam int unsigned LcrEps = 4;
    localparam int unsigned LcrSp  = 5;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_core_p_if.sv
// Bus between the UART register block (master) and the receive engine (slave).
interface uart_rx_core_p_if #(
    parameter int unsigned TOC_W = 10
);
    logic             enable;
    logic             srx_pad_i;
    logic [7:0]       lcr;
    logic             rf_pop;
    logic             rf_empty;
    logic [7:0]       rx_data;
    logic [2:0]       rx_err;
    logic             rx_push;
    logic [TOC_W-1:0] counter_t;
    logic             rx_timeout;
    logic [2:0]       rstate;

    modport master (
        output enable, srx_pad_i, lcr, rf_pop, rf_empty,
        input  rx_data, rx_err, rx_push, counter_t, rx_timeout, rstate
    );

    modport slave (
        input  enable, srx_pad_i, lcr, rf_pop, rf_empty,
        output rx_data, rx_err, rx_push, counter_t, rx_timeout, rstate
    );
endinterface

// File: rtl/uart_rx_timeout.sv
// Character-timeout counter: reloads with four character times computed from lcr,
// counts down on oversample ticks and saturates at zero.
module uart_rx_timeout
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned TOC_W      = 10
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic             enable,
    input  logic [3:0]       lcr,
    input  logic             rx_push,
    input  logic             rf_pop,
    input  logic             rf_empty,
    output logic [TOC_W-1:0] counter_t,
    output logic             rx_timeout
);
    localparam int unsigned TicksPer4Bits = 4 * OVERSAMPLE;

    logic [3:0]       frame_bits;
    logic [TOC_W-1:0] toc;
    logic [TOC_W-1:0] counter_q, counter_d;

    // start + (5 + wls) data + parity + stop + optional second stop
    always_comb begin
        frame_bits = 4'd7 + {2'b00, lcr[1:0]} + {3'b000, lcr[LcrPen]} + {3'b000, lcr[LcrStb]};
        toc        = TOC_W'(32'(frame_bits) * TicksPer4Bits - 32'd1);
    end

    always_comb begin
        counter_d = counter_q;
        if (rx_push || rf_pop || rf_empty) begin
            counter_d = toc;
        end else if (enable && (counter_q != '0)) begin
            counter_d = counter_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            counter_q <= '1;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign counter_t  = counter_q;
    assign rx_timeout = (counter_q == '0) && !rf_empty;

endmodule

// File: rtl/uart_rx_core_p.sv
// UART receive engine: 2-flop synchroniser, optional majority glitch filter
// (UART_RX_GLITCH_FILTER_EN), character FSM with parity/framing/break detection.
module uart_rx_core_p
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned TOC_W      = 10
) (
    input  logic            clk,
    input  logic            wb_rst_i,
    uart_rx_core_p_if.slave bus
);
    localparam int unsigned      ScntW    = $clog2(OVERSAMPLE);
    localparam logic [ScntW-1:0] ScntHalf = ScntW'(OVERSAMPLE / 2 - 1);
    localparam logic [ScntW-1:0] ScntLast = ScntW'(OVERSAMPLE - 1);

    logic [1:0] sync_q;
    logic       s_sync;
    logic       s;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.srx_pad_i};
        end
    end
    assign s_sync = sync_q[1];

`ifdef UART_RX_GLITCH_FILTER_EN
    // Two stored taps plus the live sample, so start detection gains only one tick.
    logic [1:0] filt_q;
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            filt_q <= 2'b11;
        end else if (bus.enable) begin
            filt_q <= {filt_q[0], s_sync};
        end
    end
    assign s = maj3({filt_q, s_sync});
`else
    assign s = s_sync;
`endif

    rx_state_e        state_q, state_d;
    logic [ScntW-1:0] scnt_q, scnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [5:0]       lcr_q, lcr_d;
    logic             par_q, par_d;
    logic [7:0]       data_q, data_d;
    logic [2:0]       err_q, err_d;
    logic             brk_q, brk_d;
    logic             perr;
    logic             brk_now;
    logic             unused_lcr;

    assign unused_lcr = ^bus.lcr[7:6];

    always_comb begin
        perr = 1'b0;
        if (lcr_q[LcrSp]) begin
            perr = (par_q != ~lcr_q[LcrEps]);
        end else if (lcr_q[LcrEps]) begin
            perr = (^shift_q) ^ par_q;
        end else begin
            perr = ~((^shift_q) ^ par_q);
        end
        brk_now = (shift_q == 8'h00) && (!lcr_q[LcrPen] || !par_q) && !s;
    end

    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        lcr_d    = lcr_q;
        par_d    = par_q;
        data_d   = data_q;
        err_d    = err_q;
        brk_d    = brk_q;
        case (state_q)
            StIdle: begin
                if (bus.enable && !s) begin
                    state_d = StStart;
                    scnt_d  = '0;
                    lcr_d   = bus.lcr[5:0];
                end
            end
            StStart: begin
                if (bus.enable) begin
                    if (scnt_q == ScntHalf) begin
                        if (s) begin
                            state_d = StIdle;
                        end else begin
                            state_d  = StData;
                            scnt_d   = '0;
                            bitcnt_d = '0;
                            shift_d  = '0;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (bus.enable) begin
                    if (scnt_q == ScntLast) begin
                        scnt_d           = '0;
                        shift_d[bitcnt_q] = s;
                        // last data bit index is NB-1 = 4 + wls
                        if (bitcnt_q == {1'b1, lcr_q[LcrWls +: 2]}) begin
                            state_d = lcr_q[LcrPen] ? StParity : StStop;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (bus.enable) begin
                    if (scnt_q == ScntLast) begin
                        scnt_d  = '0;
                        par_d   = s;
                        state_d = StStop;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (bus.enable) begin
                    if (scnt_q == ScntLast) begin
                        err_d = '0;
                        if (brk_now) begin
                            data_d        = '0;
                            err_d[ErrBrk] = 1'b1;
                            brk_d         = 1'b1;
                        end else begin
                            data_d       = shift_q;
                            err_d[ErrPe] = lcr_q[LcrPen] & perr;
                            err_d[ErrFe] = ~s;
                            brk_d        = 1'b0;
                        end
                        state_d = StPush;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StPush: begin
                state_d = brk_q ? StWaitIdle : StIdle;
            end
            StWaitIdle: begin
                if (bus.enable && s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (bus.enable) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            scnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            lcr_q    <= '0;
            par_q    <= 1'b0;
            data_q   <= '0;
            err_q    <= '0;
            brk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            lcr_q    <= lcr_d;
            par_q    <= par_d;
            data_q   <= data_d;
            err_q    <= err_d;
            brk_q    <= brk_d;
        end
    end

    assign bus.rx_data = data_q;
    assign bus.rx_err  = err_q;
    assign bus.rx_push = (state_q == StPush);
    assign bus.rstate  = state_q;

    uart_rx_timeout #(
        .OVERSAMPLE(OVERSAMPLE),
        .TOC_W     (TOC_W)
    ) u_timeout (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .enable    (bus.enable),
        .lcr       (bus.lcr[3:0]),
        .rx_push   (bus.rx_push),
        .rf_pop    (bus.rf_pop),
        .rf_empty  (bus.rf_empty),
        .counter_t (bus.counter_t),
        .rx_timeout(bus.rx_timeout)
    );

endmodule

// File: tb/tb_uart_rx_core_p.sv
// Randomised bench for uart_rx_core_p: serial frames are driven bit by bit and every
// push is compared against a frame-level model of data, error flags and arrival tick.
module tb_uart_rx_core_p;
    import uart_rx_pkg::*;

    localparam int unsigned Os   = 16;
    localparam int unsigned TocW = 10;
    localparam int unsigned Half = Os / 2;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int unsigned FiltLat = 1;
`else
    localparam int unsigned FiltLat = 0;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [2:0]  err;
        int unsigned tick;
    } push_t;

    logic        clk;
    logic        wb_rst_i;
    int unsigned tick_cnt = 0;
    int unsigned div = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          consec = 0;
    logic        prev_push = 1'b0;
    logic        toc_pending = 1'b0;
    push_t       act_q[$];
    push_t       exp_q[$];

    uart_rx_core_p_if #(.TOC_W(TocW)) bus ();

    uart_rx_core_p #(
        .OVERSAMPLE(Os),
        .TOC_W     (TocW)
    ) dut (
        .clk     (clk),
        .wb_rst_i(wb_rst_i),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.enable = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            bus.enable = (div == 0);
        end
    end

    always @(posedge clk) begin
        if (bus.enable) tick_cnt <= tick_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Four character times of the live line setting, in ticks, minus one.
    function automatic logic [31:0] toc_model(input logic [7:0] lcr);
        int unsigned f;
        f = 1 + (5 + int'(lcr[1:0])) + int'(lcr[3]) + 1 + int'(lcr[2]);
        return 32'(4 * f * Os - 1);
    endfunction

    function automatic push_t frame_model(input logic [7:0] data, input logic [7:0] lcr,
                                          input logic par_bit, input logic stop_bit,
                                          input int unsigned t0);
        push_t       m;
        int unsigned nb;
        logic [7:0]  d;
        int unsigned ones;
        logic        perr;
        nb   = 5 + int'(lcr[1:0]);
        d    = data & 8'((1 << nb) - 1);
        ones = $countones(d) + int'(par_bit);
        if (lcr[5])      perr = (par_bit != !lcr[4]);
        else if (lcr[4]) perr = (ones % 2) != 0;
        else             perr = (ones % 2) != 1;
        if (d == 0 && (!lcr[3] || !par_bit) && !stop_bit) begin
            m.data = 8'h00;
            m.err  = 3'b100;
        end else begin
            m.data = d;
            m.err  = {1'b0, lcr[3] & perr, !stop_bit};
        end
        // detection tick + half bit to start centre + one bit per remaining sample
        m.tick = t0 + 1 + FiltLat + Half + Os * (nb + int'(lcr[3]) + 1);
        return m;
    endfunction

    always @(negedge clk) begin
        if (toc_pending) check_eq("toc_reload", 32'(bus.counter_t), toc_model(bus.lcr));
        if (bus.rx_push) begin
            act_q.push_back('{data: bus.rx_data, err: bus.rx_err, tick: tick_cnt});
            if (prev_push) consec <= consec + 1;
        end
        toc_pending <= bus.rx_push;
        prev_push   <= bus.rx_push;
    end

    task automatic wait_tick();
        do @(posedge clk); while (!bus.enable);
        #1;
    endtask

    task automatic drive_bits(input logic v, input int unsigned n);
        bus.srx_pad_i = v;
        repeat (n) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit);
        int unsigned nb;
        nb = 5 + int'(bus.lcr[1:0]);
        wait_tick();
        exp_q.push_back(frame_model(data, bus.lcr, par_bit, stop_bit, tick_cnt));
        drive_bits(1'b0, Os);
        for (int i = 0; i < int'(nb); i++) drive_bits(data[i], Os);
        if (bus.lcr[3]) drive_bits(par_bit, Os);
        drive_bits(stop_bit, Os);
        drive_bits(1'b1, 24);
    endtask

    task automatic compare_pushes(input string tag);
        push_t a, e;
        check_eq({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            check_eq({tag, "_data"}, 32'(a.data), 32'(e.data));
            check_eq({tag, "_err"}, 32'(a.err), 32'(e.err));
            check_eq({tag, "_tick"}, a.tick, e.tick);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        logic        seen_start;
        wb_rst_i      = 1'b1;
        bus.srx_pad_i = 1'b1;
        bus.lcr       = 8'h03;
        bus.rf_pop    = 1'b0;
        bus.rf_empty  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rstate", 32'(bus.rstate), 32'(StIdle));
        check_eq("rst_rx_data", 32'(bus.rx_data), 32'h0);
        check_eq("rst_rx_err", 32'(bus.rx_err), 32'h0);
        check_eq("rst_rx_push", 32'(bus.rx_push), 32'h0);
        check_eq("rst_counter_t", 32'(bus.counter_t), 32'h3ff);
        check_eq("rst_rx_timeout", 32'(bus.rx_timeout), 32'h0);
        wb_rst_i = 1'b0;
        drive_bits(1'b1, 20);

        // 8N1 0x5A
        send_frame(8'h5a, 1'b0, 1'b1);
        compare_pushes("f8n1");

        // 7-bit even parity, 0x41 with the wrong parity bit
        bus.lcr = 8'h1a;
        send_frame(8'h41, 1'b1, 1'b1);
        compare_pushes("f7e1");

        // 5-tick low pulse: START is entered, then rejected as a false start
        bus.lcr = 8'h03;
        seen_start = 1'b0;
        bus.srx_pad_i = 1'b0;
        repeat (5) begin
            wait_tick();
            if (bus.rstate == StStart) seen_start = 1'b1;
        end
        drive_bits(1'b1, 30);
        check_eq("pulse_saw_start", 32'(seen_start), 32'h1);
        check_eq("pulse_idle", 32'(bus.rstate), 32'(StIdle));
        compare_pushes("pulse");

`ifdef UART_RX_GLITCH_FILTER_EN
        seen_start = 1'b0;
        bus.srx_pad_i = 1'b0;
        wait_tick();
        bus.srx_pad_i = 1'b1;
        repeat (10) begin
            wait_tick();
            if (bus.rstate != StIdle) seen_start = 1'b1;
        end
        check_eq("glitch_stays_idle", 32'(seen_start), 32'h0);
        compare_pushes("glitch");
`endif

        // Break: line low for three frame times, one push, hold WAIT_IDLE until high
        wait_tick();
        exp_q.push_back(frame_model(8'h00, bus.lcr, 1'b0, 1'b0, tick_cnt));
        drive_bits(1'b0, 30 * Os);
        check_eq("brk_wait_idle", 32'(bus.rstate), 32'(StWaitIdle));
        drive_bits(1'b1, 4);
        check_eq("brk_back_idle", 32'(bus.rstate), 32'(StIdle));
        compare_pushes("brk");
        send_frame(8'h33, 1'b0, 1'b1);
        compare_pushes("after_brk");

        // Timeout: reload by pop, count down to zero, saturate, reload by pop
        wait_tick();
        bus.rf_pop = 1'b1;
        @(posedge clk);
        #1;
        bus.rf_pop = 1'b0;
        check_eq("toc_pop_load", 32'(bus.counter_t), 32'd639);
        n = 0;
        while (bus.counter_t != 0 && n < 2000) begin
            wait_tick();
            n++;
        end
        check_eq("toc_ticks", n, 32'd639);
        check_eq("toc_flag", 32'(bus.rx_timeout), 32'h1);
        repeat (3) wait_tick();
        check_eq("toc_saturate", 32'(bus.counter_t), 32'h0);
        bus.rf_pop = 1'b1;
        @(posedge clk);
        #1;
        bus.rf_pop = 1'b0;
        check_eq("toc_pop_reload", 32'(bus.counter_t), 32'd639);
        check_eq("toc_flag_clear", 32'(bus.rx_timeout), 32'h0);

        // Reset during the data phase
        wait_tick();
        drive_bits(1'b0, Os);
        drive_bits(1'b1, Os);
        check_eq("mid_in_data", 32'(bus.rstate), 32'(StData));
        #2;
        wb_rst_i = 1'b1;
        #1;
        check_eq("mid_rst_rstate", 32'(bus.rstate), 32'(StIdle));
        check_eq("mid_rst_rx_data", 32'(bus.rx_data), 32'h0);
        check_eq("mid_rst_rx_err", 32'(bus.rx_err), 32'h0);
        check_eq("mid_rst_counter_t", 32'(bus.counter_t), 32'h3ff);
        repeat (3) @(negedge clk);
        check_eq("mid_rst_rx_push", 32'(bus.rx_push), 32'h0);
        wb_rst_i = 1'b0;
        drive_bits(1'b1, 20);
        send_frame(8'hc6, 1'b0, 1'b1);
        compare_pushes("after_rst");

        // Random line settings, data, parity and stop bits
        for (int k = 0; k < 16; k++) begin
            bus.lcr = {2'b00, 6'($urandom_range(63))};
            send_frame(8'($urandom_range(255)), 1'($urandom_range(1)),
                       ($urandom_range(3) != 0));
            compare_pushes("rand");
        end

        check_eq("no_back_to_back_push", 32'(consec), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
